// File: rtl/utm_tape_controller_if.sv
// Core-side bundle of the UTM tape controller: symbol/state issue and transition results.
interface utm_tape_controller_if;
   logic       core_mode;
   logic [2:0] core_state;
   logic [2:0] core_sym;
   logic       core_sym_valid;
   logic [2:0] core_new_sym;
   logic       core_direction;
   logic [2:0] core_next_state;

   modport master (
      output core_mode, core_state, core_sym, core_sym_valid,
      input  core_new_sym, core_direction, core_next_state
   );

   modport slave (
      input  core_mode, core_state, core_sym, core_sym_valid,
      output core_new_sym, core_direction, core_next_state
   );
endinterface

// File: rtl/utm_tape_controller.sv
// Tape/head sequencer for a UTM transition core: issue symbol, wait for the core, commit result.
// Optional step limit: define UTM_STEP_LIMIT_EN to add the max_steps input and timeout output.
module utm_tape_controller #(
   parameter int unsigned TAPE_LEN     = 16,
   parameter int unsigned CORE_LATENCY = 8,
   parameter logic [2:0]  HALT_STATE   = 3'b111
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  single_step,
   input  logic                  load_en,
   input  logic [3:0]            load_addr,
   input  logic [2:0]            load_sym,
   utm_tape_controller_if.master core,
   output logic                  busy,
   output logic                  halted,
   output logic                  fault,
   output logic [3:0]            head_pos,
`ifdef UTM_STEP_LIMIT_EN
   input  logic [15:0]           max_steps,
   output logic                  timeout,
`endif
   output logic [15:0]           step_count
);
   localparam int unsigned SYM_W  = 3;
   localparam int unsigned HEAD_W = 4;
   localparam int unsigned STEP_W = 16;
   localparam int unsigned CNT_W  = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
   localparam logic [HEAD_W-1:0] HEAD_MAX = HEAD_W'(TAPE_LEN - 1);
   localparam logic [HEAD_W:0]   ADDR_LIM = (HEAD_W + 1)'(TAPE_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMMIT,
      S_HALT
   } fsm_e;

   fsm_e              fsm_q, fsm_d;
   logic [SYM_W-1:0]  tape_q [TAPE_LEN];
   logic [HEAD_W-1:0] head_q, head_d;
   logic [SYM_W-1:0]  state_q;
   logic [SYM_W-1:0]  sym_q, sym_fwd;
   logic [STEP_W-1:0] step_q;
   logic [CNT_W-1:0]  wait_q;
   logic              single_q;
   logic              busy_q, halted_q, fault_q, timeout_q, sym_valid_q;
   logic              load_ok, start_ok, at_edge, limit_hit, stop_run;

   // State register
   always_ff @(posedge clock) begin
      if (reset) fsm_q <= S_IDLE;
      else       fsm_q <= fsm_d;
   end

   // Next-state and datapath control decode
   always_comb begin
      fsm_d     = fsm_q;
      load_ok   = (fsm_q == S_IDLE) && load_en && ({1'b0, load_addr} < ADDR_LIM);
      start_ok  = start && ((fsm_q == S_IDLE) || (fsm_q == S_HALT));
      at_edge   = ((head_q == '0) && !core.core_direction) ||
                  ((head_q == HEAD_MAX) && core.core_direction);
      limit_hit = 1'b0;
`ifdef UTM_STEP_LIMIT_EN
      limit_hit = (max_steps != '0) &&
                  ((17'(step_q) + 17'd1) == 17'(max_steps));
`endif
      stop_run  = at_edge || (core.core_next_state == HALT_STATE) || limit_hit;
      head_d    = core.core_direction ? (head_q + HEAD_W'(1)) : (head_q - HEAD_W'(1));
      // A same-cycle load to the head cell must be visible to the issue that follows
      sym_fwd   = (load_ok && (load_addr == head_q)) ? load_sym : tape_q[head_q];

      unique case (fsm_q)
         S_IDLE, S_HALT: if (start) fsm_d = S_ISSUE;
         S_ISSUE:        fsm_d = S_WAIT;
         S_WAIT:         if (wait_q == '0) fsm_d = S_COMMIT;
         S_COMMIT: begin
            if (stop_run)      fsm_d = S_HALT;
            else if (single_q) fsm_d = S_IDLE;
            else               fsm_d = S_ISSUE;
         end
         default:        fsm_d = S_IDLE;
      endcase
   end

   // Tape, head, machine state, counters and registered status
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(TAPE_LEN); i++) tape_q[i] <= '0;
         head_q      <= '0;
         state_q     <= '0;
         sym_q       <= '0;
         step_q      <= '0;
         wait_q      <= '0;
         single_q    <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         fault_q     <= 1'b0;
         timeout_q   <= 1'b0;
         sym_valid_q <= 1'b0;
      end else begin
         if (load_ok) tape_q[load_addr] <= load_sym;
         if (start_ok) begin
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
            single_q  <= single_step;
            sym_q     <= sym_fwd;
         end
         if (fsm_q == S_ISSUE)
            wait_q <= CNT_W'(CORE_LATENCY - 1);
         else if ((fsm_q == S_WAIT) && (wait_q != '0))
            wait_q <= wait_q - CNT_W'(1);
         if (fsm_q == S_COMMIT) begin
            tape_q[head_q] <= core.core_new_sym;
            state_q        <= core.core_next_state;
            if (step_q != '1) step_q <= step_q + STEP_W'(1);
            fault_q        <= at_edge;
            timeout_q      <= limit_hit;
            if (!at_edge) head_q <= head_d;
            // Continuing runs never revisit the cell just written, so the old tape value is current
            if (fsm_d == S_ISSUE) sym_q <= tape_q[head_d];
         end
         busy_q      <= (fsm_d == S_ISSUE) || (fsm_d == S_WAIT) || (fsm_d == S_COMMIT);
         halted_q    <= (fsm_d == S_HALT);
         sym_valid_q <= (fsm_d == S_ISSUE);
      end
   end

   assign core.core_mode      = 1'b1;
   assign core.core_state     = state_q;
   assign core.core_sym       = sym_q;
   // Reset kills a pending issue pulse in the very cycle it is asserted
   assign core.core_sym_valid = sym_valid_q && !reset;
   assign busy                = busy_q;
   assign halted              = halted_q;
   assign fault               = fault_q;
   assign head_pos            = head_q;
   assign step_count          = step_q;
`ifdef UTM_STEP_LIMIT_EN
   assign timeout             = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout      = timeout_q;
`endif
endmodule

// File: doc/utm_tape_controller.md
UTM_TAPE_CONTROLLER -- requirements
Module: utm_tape_controller

Interface
REQ-001 Parameter TAPE_LEN, default 16: tape cells, each 3 bits; head width 4 bits.
REQ-002 Parameter CORE_LATENCY, default 8: cycles from core sym_in_valid pulse to core outputs valid.
REQ-003 Parameter HALT_STATE, default 3'b111: encoded state that terminates a run.
REQ-004 clock  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  pulse; begins execution from IDLE.
REQ-007 single_step  in  1  sampled at start; 1 = execute one transition then return to IDLE.
REQ-008 load_en / load_addr[3:0] / load_sym[2:0]  in  tape write port, honoured only in IDLE.
REQ-009 core_mode  out  1  tied 1 (execute mode).
REQ-010 core_state  out  3  current encoded state to core encoded_state_in.
REQ-011 core_sym / core_sym_valid  out  3 / 1  symbol under head, one-cycle valid pulse.
REQ-012 core_new_sym / core_direction / core_next_state  in  3 / 1 / 3  core results; direction 1 = right, 0 = left.
REQ-013 busy / halted / fault  out  1 each  status.
REQ-014 head_pos  out  4;  step_count  out  16.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, COMMIT, HALT; encoding free.
REQ-016 IDLE: start=1 -> ISSUE; start ignored in any other state; IDLE with halted=1 still accepts start.
REQ-017 ISSUE (1 cycle): core_sym_valid=1, core_sym=tape[head_pos]; -> WAIT; wait counter loaded with CORE_LATENCY-1.
REQ-018 WAIT: decrement counter each cycle; at 0 -> COMMIT; core_sym and core_state held stable throughout.
REQ-019 COMMIT (1 cycle): tape[head_pos]<=core_new_sym, state<=core_next_state, step_count+=1 (saturates at 16'hFFFF).
REQ-020 COMMIT head move: direction 1 -> head+1, 0 -> head-1, unless boundary (REQ-022).
REQ-021 COMMIT next: next_state==HALT_STATE -> HALT; else single_step -> IDLE; else ISSUE.
REQ-022 Boundary: head==0 with left, or head==TAPE_LEN-1 with right -> symbol and state still committed, head unchanged, fault=1, -> HALT.
REQ-023 HALT: halted=1, busy=0; stays until start (-> ISSUE, clears halted/fault, state, head, step_count retained) or reset.
REQ-024 busy=1 in ISSUE, WAIT, COMMIT; 0 in IDLE, HALT.
REQ-025 load_en in IDLE writes tape[load_addr]; ignored in other states; load_addr >= TAPE_LEN ignored; load_en and start same cycle: load performed, start taken.
REQ-026 Full-speed run: one transition per CORE_LATENCY+2 cycles.

Reset
REQ-027 reset forces IDLE from any state, mid-run included; same cycle drives core_sym_valid=0.
REQ-028 Reset values: state=3'b000, head_pos=0, step_count=0, all tape cells 3'b000, busy=halted=fault=0, core_sym=0.

Configuration
REQ-029 Macro UTM_STEP_LIMIT_EN defined: input max_steps[15:0] and output timeout present; COMMIT with step_count+1 == max_steps (max_steps != 0) -> HALT, timeout=1; timeout clears like fault.
REQ-030 UTM_STEP_LIMIT_EN undefined: max_steps and timeout ports absent; no step limit; all other behaviour unchanged.

Verification
REQ-031 Reset 5 cycles, no load -> all outputs at REQ-028 values, core_sym_valid never asserted.
REQ-032 Load tape[0]=3'b001, core model returns new_sym=3'b010, dir=1, next=3'b001, single_step=1, start -> sym_valid pulse with core_sym=001, tape[0]=010, head_pos=1, step_count=1, IDLE after 10 cycles.
REQ-033 Core model returns next=3'b111 on 3rd transition, free run -> halted=1 after exactly 3 COMMITs (30 cycles), fault=0.
REQ-034 head_pos=0, core dir=0 -> symbol written, head stays 0, fault=1, halted=1.
REQ-035 reset asserted in WAIT of 2nd transition -> next cycle IDLE, tape cleared, no COMMIT occurs.
REQ-036 With UTM_STEP_LIMIT_EN, max_steps=4, non-halting core -> timeout=1, step_count=4; without macro same stimulus runs past 4 steps.
